// File: rtl/serve_pkg.sv
// Shared constants for the serve unit: state encodings and the served-count width.
package serve_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 8;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_SERVE = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE  = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = S_IDLE,
    ST_SERVE = S_SERVE,
    ST_DONE  = S_DONE
  } state_e;

endpackage

// File: rtl/serve_unit_if.sv
// Queue-to-server link: first-word-fall-through head entry plus the pop strobe.
interface serve_unit_if #(
  parameter int unsigned DT_SZ = 4
);
  logic             empty;
  logic [DT_SZ-1:0] qn;
  logic [DT_SZ-1:0] qt;
  logic             re;

  modport master (output empty, output qn, output qt, input re);
  modport slave  (input empty, input qn, input qt, output re);
endinterface

// File: rtl/tick_gen.sv
// Prescaler producing one tick every TICK_DIV enabled cycles; clear wins over enable.
module tick_gen #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned DIV_W    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_c_o
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  always_comb begin
    count_d  = count_q;
    tick_c_o = en_i && (count_q == LAST);
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serve_unit.sv
// Pops the queue head when idle, counts its service time down in prescaled units,
// then pulses done for one cycle and bumps the served counter.
module serve_unit
  import serve_pkg::*;
#(
  parameter int unsigned DT_SZ    = 4,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned DIV_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  serve_unit_if.slave        q,
  input  logic               hold_i,
  output logic [DT_SZ-1:0]   cur_num_o,
  output logic [DT_SZ-1:0]   remain_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   served_cnt_o,
  output logic [STATE_W-1:0] state_dbg_o
);

  state_e             state_q, state_d;
  logic [DT_SZ-1:0]   cur_num_q, cur_num_d;
  logic [DT_SZ-1:0]   remain_q, remain_d;
  logic [CNT_W-1:0]   served_q, served_d;
  logic               busy_q, done_q;
  logic               re_c;
  logic               tick_c;

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != ST_SERVE),
    .en_i     ((state_q == ST_SERVE) && !hold_i),
    .tick_c_o (tick_c)
  );

  // Next-state and datapath updates; re is only ever raised from IDLE.
  always_comb begin
    state_d   = state_q;
    cur_num_d = cur_num_q;
    remain_d  = remain_q;
    served_d  = served_q;
    re_c      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        re_c = !q.empty && !hold_i && !rst;
        if (re_c) begin
          cur_num_d = q.qn;
          remain_d  = q.qt;
          state_d   = (q.qt != '0) ? ST_SERVE : ST_DONE;
        end
      end
      ST_SERVE: begin
        if (tick_c && (remain_q != '0)) begin
          remain_d = remain_q - DT_SZ'(1);
          if (remain_q == DT_SZ'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        served_d = served_q + CNT_W'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy/done are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_num_q <= '0;
      remain_q  <= '0;
      served_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_num_q <= cur_num_d;
      remain_q  <= remain_d;
      served_q  <= served_d;
      busy_q    <= (state_d == ST_SERVE) || (state_d == ST_DONE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign q.re         = re_c;
  assign cur_num_o    = cur_num_q;
  assign remain_o     = remain_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign served_cnt_o = served_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_serve_unit.sv
// Directed bench for serve_unit with a depth-3 FWFT queue and a time-unit reference model.
module tb_serve_unit;
  import serve_pkg::*;

  localparam int unsigned DT    = 4;
  localparam int unsigned TD    = 2;
  localparam int unsigned DW    = 1;
  localparam int          DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic [DT-1:0] cur_num, remain;
  logic          busy, done;
  logic [7:0]    served;
  logic [1:0]    sdbg;

  serve_unit_if #(.DT_SZ(DT)) q_if ();

  serve_unit #(.DT_SZ(DT), .TICK_DIV(TD), .DIV_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .q            (q_if),
    .hold_i       (hold),
    .cur_num_o    (cur_num),
    .remain_o     (remain),
    .busy_o       (busy),
    .done_o       (done),
    .served_cnt_o (served),
    .state_dbg_o  (sdbg)
  );

  always #5 clk = ~clk;

  // Queue feeding the unit
  int fq_n [DEPTH];
  int fq_t [DEPTH];
  int fcnt = 0;
  bit push_req = 0;
  int push_n = 0, push_t = 0;
  assign q_if.empty = (fcnt == 0);
  assign q_if.qn    = DT'(fq_n[0]);
  assign q_if.qt    = DT'(fq_t[0]);

  int n_checks = 0, n_err = 0;
  int cyc = 0;
  int n_re = 0, n_done = 0, n_busy = 0, last_re = 0, last_done = 0;
  int re_log[$];
  int done_cyc_log[$];
  int done_num_log[$];
  bit re_s = 0;
  bit chk_en = 0;

  // Model: an active job is done once it has seen T*TD unheld cycles
  bit m_act = 0;
  int m_num = 0, m_t = 0, m_el = 0, m_served = 0;
  int e_remain, e_state;
  bit e_done, e_re;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      e_done   = m_act && (m_el == m_t * int'(TD));
      e_remain = m_act ? m_t - m_el / int'(TD) : 0;
      e_state  = !m_act ? 0 : (e_done ? 2 : 1);
      e_re     = !m_act && (fcnt != 0) && !hold && !rst;
      chk("re",      int'(q_if.re), int'(e_re));
      chk("done",    int'(done),    int'(e_done));
      chk("busy",    int'(busy),    int'(m_act));
      chk("state",   int'(sdbg),    e_state);
      chk("remain",  int'(remain),  e_remain);
      chk("cur_num", int'(cur_num), m_num);
      chk("served",  int'(served),  m_served);
    end
    re_s = q_if.re;
    if (q_if.re) begin n_re++; last_re = cyc; re_log.push_back(cyc); end
    if (done) begin
      n_done++; last_done = cyc;
      done_cyc_log.push_back(cyc);
      done_num_log.push_back(int'(cur_num));
    end
    if (busy) n_busy++;
  end

  // Model and queue advance just after each edge, using the pre-edge inputs
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      m_act = 0; m_num = 0; m_served = 0;
    end else if (m_act) begin
      if (m_el == m_t * int'(TD)) begin
        m_act = 0; m_served = (m_served + 1) % 256;
      end else if (!hold) begin
        m_el++;
      end
    end else if (fcnt != 0 && !hold) begin
      m_act = 1; m_num = fq_n[0]; m_t = fq_t[0]; m_el = 0;
    end
    if (re_s && fcnt > 0) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        fq_n[i] = fq_n[i+1]; fq_t[i] = fq_t[i+1];
      end
      fcnt--;
    end
    if (push_req && fcnt < DEPTH) begin
      fq_n[fcnt] = push_n; fq_t[fcnt] = push_t; fcnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    rst = 1; step(1); rst = 0;
  endtask

  task automatic push(input int n, input int t);
    push_req = 1; push_n = n; push_t = t; step(1); push_req = 0;
  endtask

  task automatic wait_re(input int base, input string nm);
    for (int i = 0; i < 60; i++) begin
      if (n_re > base) return;
      step(1);
    end
    timeout(nm);
  endtask

  task automatic wait_done(input int target, input string nm);
    for (int i = 0; i < 100; i++) begin
      if (n_done >= target) begin step(1); return; end
      step(1);
    end
    timeout(nm);
  endtask

  int b_re, b_dn, b_bz, rl0, dl0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin fq_n[i] = 0; fq_t[i] = 0; end
    step(2);
    rst = 0; chk_en = 1;
    chk("rst_state", int'(sdbg), 0);
    chk("rst_served", int'(served), 0);
    chk("rst_re", int'(q_if.re), 0);

    // single entry (1,3): remain 3,2,1,0 every two cycles, done 7 cycles after re
    b_re = n_re;
    push(1, 3);
    wait_re(b_re, "s1_re");
    chk("s1_cur", int'(cur_num), 1);
    chk("s1_rem3", int'(remain), 3);
    step(2); chk("s1_rem2", int'(remain), 2);
    step(2); chk("s1_rem1", int'(remain), 1);
    step(2); chk("s1_rem0", int'(remain), 0);
    chk("s1_done_state", int'(sdbg), 2);
    step(1);
    chk("s1_idle", int'(sdbg), 0);
    chk("s1_served", int'(served), 1);
    chk("s1_re_count", n_re - b_re, 1);
    chk("s1_latency", last_done - last_re, 7);

    // three entries pushed while busy
    do_reset();
    b_re = n_re; b_dn = n_done; rl0 = re_log.size(); dl0 = done_num_log.size();
    push(1, 3); push(2, 2); push(3, 1);
    wait_done(b_dn + 3, "s2_done");
    step(10);
    chk("s2_re_count", n_re - b_re, 3);
    chk("s2_gap12", re_log[rl0+1] - re_log[rl0], 8);
    chk("s2_gap23", re_log[rl0+2] - re_log[rl0+1], 6);
    chk("s2_idle1", re_log[rl0+1] - done_cyc_log[dl0], 1);
    chk("s2_order1", done_num_log[dl0], 1);
    chk("s2_order2", done_num_log[dl0+1], 2);
    chk("s2_order3", done_num_log[dl0+2], 3);
    chk("s2_served", int'(served), 3);

    // zero service time
    do_reset();
    b_dn = n_done; b_bz = n_busy;
    push(7, 0);
    wait_done(b_dn + 1, "s3_done");
    step(3);
    chk("s3_latency", last_done - last_re, 1);
    chk("s3_busy_cycles", n_busy - b_bz, 1);
    chk("s3_cur", int'(cur_num), 7);
    chk("s3_remain", int'(remain), 0);

    // hold for five cycles mid-count, then hold in IDLE with a waiting entry
    do_reset();
    b_re = n_re; b_dn = n_done;
    push(4, 4);
    wait_re(b_re, "s4_re");
    step(3);
    hold = 1;
    step(4);
    chk("s4_frozen", int'(remain), 3);
    step(1);
    hold = 0;
    wait_done(b_dn + 1, "s4_done");
    chk("s4_latency", last_done - last_re, 14);
    b_re = n_re; b_dn = n_done;
    hold = 1;
    push(9, 1);
    step(5);
    chk("s4_hold_idle_re", n_re - b_re, 0);
    chk("s4_hold_idle_busy", int'(busy), 0);
    hold = 0;
    wait_done(b_dn + 1, "s4_done2");
    chk("s4_served", int'(served), 2);
    chk("s4_last_num", done_num_log[done_num_log.size()-1], 9);

    // reset in the middle of serving (5,5)
    b_re = n_re;
    push(5, 5);
    wait_re(b_re, "s5_re");
    step(4);
    rst = 1; step(1); rst = 0;
    chk("s5_state", int'(sdbg), 0);
    chk("s5_remain", int'(remain), 0);
    chk("s5_cur", int'(cur_num), 0);
    chk("s5_served", int'(served), 0);
    b_dn = n_done; b_re = n_re;
    step(15);
    chk("s5_no_done", n_done - b_dn, 0);
    chk("s5_no_refetch", n_re - b_re, 0);

    // 256 zero-time services wrap the counter
    b_dn = n_done;
    for (int i = 0; i < 256; i++) begin
      push(i % 16, 0);
      wait_done(b_dn + i + 1, "s6_done");
      if (i == 254) chk("s6_served255", int'(served), 255);
    end
    step(2);
    chk("s6_wrap", int'(served), 0);
    chk("s6_done_count", n_done - b_dn, 256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/serve_unit.md
# serve_unit

Downstream consumer of the customer queue: whenever the queue is non-empty and the unit is idle, it pops the head entry (number `qn`, service time `qt`) and serves it. Service counts down `qt` time units, each `TICK_DIV` clock cycles long, then emits a one-cycle `done` pulse. It drives the queue's `re` input directly and presents the currently served number and remaining time to the display stage.

## Interface
- `DT_SZ`, 4: width of number and time fields; must match the queue's `DT_SZ`.
- `TICK_DIV`, 4: clock cycles per service time unit; must be ≥1.
- `DIV_W`, 2: width of the prescaler counter; must satisfy 2^DIV_W ≥ TICK_DIV.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `empty`, input, 1: queue empty flag; the head entry is valid when 0.
- `qn`, input, DT_SZ: head-entry number (first-word-fall-through; valid while `empty`=0).
- `qt`, input, DT_SZ: head-entry service time in units.
- `hold`, input, 1: pause; freezes the prescaler and countdown, and blocks new fetches.
- `re`, output, 1: pop strobe to the queue; combinational.
- `cur_num`, output, DT_SZ: number being served; registered.
- `remain`, output, DT_SZ: remaining time units; registered.
- `busy`, output, 1: high in SERVE and DONE.
- `done`, output, 1: one-cycle pulse when service completes.
- `served_cnt`, output, 8: total completed services; wraps 255→0.
- `state_dbg`, output, 2: current state encoding.

## Operation
- States:
  - IDLE=0.
  - SERVE=1.
  - DONE=2.
  - Encoding 3 is illegal; if reached, the next state is IDLE.
- `re` = (state==IDLE) & !empty & !hold & !rst. It is never asserted in any other state, so the unit cannot over-read an empty queue.
- IDLE, on an edge where `re`=1:
  - `cur_num`←`qn`, `remain`←`qt`, prescaler←0.
  - Next state is SERVE if `qt`≠0, or DONE if `qt`=0.
- SERVE, when `hold`=0, the prescaler increments every cycle. At prescaler==TICK_DIV-1 a tick occurs:
  - Prescaler←0 and `remain`←`remain`-1.
  - If `remain` was 1, next state is DONE.
- SERVE, when `hold`=1, the prescaler and `remain` hold their values and the state stays SERVE.
- DONE lasts exactly one cycle:
  - `done`=1 and `served_cnt` increments on the exiting edge.
  - Next state is IDLE regardless of `hold`.
  - `cur_num` keeps its value, so the display keeps showing the last served number. `remain` is 0.
- Reset, effective on the next edge, in any state:
  - state←IDLE, `cur_num`←0, `remain`←0, prescaler←0, `served_cnt`←0.
  - Outputs `done`=0, `busy`=0, `re`=0.
  - An entry already popped is discarded and not re-fetched.
- `remain` never underflows: a decrement occurs only when `remain`≥1.

## Timing
- A pop edge E loads an entry with `qt`=T≥1:
  - The state is SERVE from E to E+T·TICK_DIV.
  - `done` is high in the cycle following edge E+T·TICK_DIV.
  - The state is IDLE after edge E+T·TICK_DIV+1.
- `qt`=0: `done` is high in the cycle after E.
- Back-to-back entries, with a non-empty queue and `hold`=0:
  - One pop every T·TICK_DIV+2 cycles.
  - A gap of exactly one IDLE cycle, during which `re`=1.
- `hold` asserted for H cycles during SERVE delays `done` by exactly H cycles.
- `hold` does not stretch DONE.
- `re` is asserted in the same cycle that `empty` deasserts, provided the state is IDLE and `hold`=0.

## Structure
- Shared package `serve_pkg` holds:
  - State localparams `S_IDLE`, `S_SERVE`, `S_DONE` (2-bit).
  - The `served_cnt` width constant, 8.
- Sub-module `tick_gen` (parameters TICK_DIV, DIV_W):
  - Inputs `clk`, `rst`, `clr`, `en`.
  - Output `tick`, high when count==TICK_DIV-1 and `en`=1.
  - `clr` has priority over `en`.
- Top level: the FSM, datapath registers, and combinational `re`.

## Test plan
- Instantiate with TICK_DIV=2 driving the queue with DEPTH=3. All `re` and `done` cycle counts are checked against the Timing section, with T=3 and TICK_DIV=2.
- Reset, then push (1,3) → `re` pulses once, `cur_num`=1, `remain` steps 3,2,1,0 every 2 cycles, `done` high in cycle E+7, `served_cnt`=1.
- Push (1,3), (2,2), (3,1) while the unit is busy → served in order 1,2,3. Exactly one IDLE cycle between services, 3 `re` pulses, `served_cnt`=3. `empty`=1 afterwards, with no further `re`.
- Push (7,0) → `done` in the cycle after the pop, `remain` stays 0, `busy` high for 1 cycle.
- Serving (4,4), assert `hold` for 5 cycles mid-count → `remain` frozen, `done` delayed by exactly 5 cycles. With the queue non-empty and `hold` high in IDLE, `re` stays 0.
- Assert `rst` for one cycle during SERVE of (5,5) → next cycle state=IDLE, `remain`=0, `cur_num`=0, `served_cnt`=0, `done` never pulses.
- Complete 256 services with `qt`=0 → `served_cnt` wraps to 0.
